// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, levels and requester indices for the writeback arbiter
package regfile_wb_arbiter_pkg;
  localparam int RF_NUM_REQ = 3;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam logic RF_WE_ON = 1'b1;
  localparam logic [RF_DATA_W-1:0] RF_ZERO = '0;
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: requester, register-file write and hazard-check signals
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) ();
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] chk_addr_1;
  logic [ADDR_W-1:0] chk_addr_2;
  logic hazard_1;
  logic hazard_2;
  modport master (
    output req_valid, req_addr, req_data, chk_addr_1, chk_addr_2,
    input req_ready, write_en, write_addr, write_data, hazard_1, hazard_2
  );
  modport slave (
    input req_valid, req_addr, req_data, chk_addr_1, chk_addr_2,
    output req_ready, write_en, write_addr, write_data, hazard_1, hazard_2
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// rr_pick: round-robin one-hot pick starting one past the last grant
module rr_pick #(
  parameter int N = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  int w_j;
  // Walk from farthest to nearest so the nearest valid requester wins
  always_comb begin
    o_grant = '0;
    o_idx = i_last;
    o_any = 1'b0;
    w_j = 0;
    for (int k = N; k >= 1; k--) begin
      w_j = (int'(i_last) + k) % N;
      if (i_valid[w_j]) begin
        o_grant = '0;
        o_grant[w_j] = 1'b1;
        o_idx = IW'(w_j);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter with registered write port and hazard check
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] w_valid;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0] w_idx;
  logic w_any;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic w_hit_1;
  logic w_hit_2;
  logic [IW-1:0] r_last;
  logic r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  assign w_valid = rst ? '0 : bus.req_valid;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_valid(w_valid),
    .i_last(r_last),
    .o_grant(w_grant),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  assign w_addr = bus.req_addr[w_idx*ADDR_W +: ADDR_W];
  assign w_data = bus.req_data[w_idx*DATA_W +: DATA_W];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IW'(NUM_REQ - 1);
      r_we <= ~RF_WE_ON;
      r_addr <= '0;
      r_data <= DATA_W'(RF_ZERO);
    end else begin
      r_we <= (w_any && w_addr != '0) ? RF_WE_ON : ~RF_WE_ON;
      if (w_any) begin
        r_last <= w_idx;
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  end
  // Output-stage term is suppressed during reset because that write is being dropped
  always_comb begin
    w_hit_1 = (r_we == RF_WE_ON) && !rst && r_addr == bus.chk_addr_1;
    w_hit_2 = (r_we == RF_WE_ON) && !rst && r_addr == bus.chk_addr_2;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_hit_1 = w_hit_1 | (bus.req_valid[i] && bus.req_addr[i*ADDR_W +: ADDR_W] == bus.chk_addr_1);
      w_hit_2 = w_hit_2 | (bus.req_valid[i] && bus.req_addr[i*ADDR_W +: ADDR_W] == bus.chk_addr_2);
    end
  end
  assign bus.req_ready = w_grant;
  assign bus.write_en = r_we;
  assign bus.write_addr = r_addr;
  assign bus.write_data = r_data;
  assign bus.hazard_1 = w_hit_1 && bus.chk_addr_1 != '0;
  assign bus.hazard_2 = w_hit_2 && bus.chk_addr_2 != '0;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of arbitration, write port, hazards and reset
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_err = 0;
  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr[i*5 +: 5] = a;
    bus.req_data[i*32 +: 32] = d;
  endtask
  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.chk_addr_1 = '0;
    bus.chk_addr_2 = '0;
    tick();
    tick();
    set_req(REQ_ALU, 5'd1, 32'h100);
    set_req(REQ_LSU, 5'd2, 32'h200);
    set_req(REQ_MDU, 5'd3, 32'h300);
    bus.req_valid = 3'b111;
    bus.chk_addr_1 = 5'd3;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_we", 64'(bus.write_en), 64'h0);
    chk("rst_addr", 64'(bus.write_addr), 64'h0);
    chk("rst_data", 64'(bus.write_data), 64'h0);
    chk("rst_hazard_1", 64'(bus.hazard_1), 64'h1);
    chk("rst_hazard_2_zero", 64'(bus.hazard_2), 64'h0);
    tick();
    rst = 1'b0;
    bus.chk_addr_1 = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 64'(bus.req_ready), 64'(3'b001 << (k % 3)));
      tick();
      if (k == 5) bus.req_valid = '0;
      chk("rr_we", 64'(bus.write_en), 64'h1);
      chk("rr_addr", 64'(bus.write_addr), 64'((k % 3) + 1));
      chk("rr_data", 64'(bus.write_data), 64'(((k % 3) + 1) * 32'h100));
    end
    #1;
    chk("idle_ready", 64'(bus.req_ready), 64'h0);
    tick();
    chk("idle_we", 64'(bus.write_en), 64'h0);
    chk("idle_addr_hold", 64'(bus.write_addr), 64'h3);
    chk("idle_data_hold", 64'(bus.write_data), 64'h300);
    set_req(REQ_LSU, 5'd5, 32'hDEADBEEF);
    bus.req_valid = 3'b010;
    #1;
    chk("single_ready", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = '0;
    chk("single_we", 64'(bus.write_en), 64'h1);
    chk("single_addr", 64'(bus.write_addr), 64'h5);
    chk("single_data", 64'(bus.write_data), 64'hDEADBEEF);
    set_req(REQ_ALU, 5'd0, 32'h1234);
    bus.req_valid = 3'b001;
    #1;
    chk("zero_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    chk("zero_we", 64'(bus.write_en), 64'h0);
    set_req(REQ_MDU, 5'd7, 32'h77);
    bus.req_valid = 3'b100;
    bus.chk_addr_1 = 5'd7;
    bus.chk_addr_2 = 5'd0;
    #1;
    chk("haz_ready", 64'(bus.req_ready), 64'h4);
    chk("haz_pending_1", 64'(bus.hazard_1), 64'h1);
    chk("haz_pending_2", 64'(bus.hazard_2), 64'h0);
    tick();
    bus.req_valid = '0;
    #1;
    chk("haz_stage_we", 64'(bus.write_en), 64'h1);
    chk("haz_stage_1", 64'(bus.hazard_1), 64'h1);
    tick();
    chk("haz_clear_1", 64'(bus.hazard_1), 64'h0);
    bus.chk_addr_1 = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(REQ_ALU, 5'd9, 32'hA);
    set_req(REQ_MDU, 5'd9, 32'hB);
    bus.req_valid = 3'b101;
    #1;
    chk("same_ready_0", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 3'b100;
    #1;
    chk("same_ready_2", 64'(bus.req_ready), 64'h4);
    chk("same_first_addr", 64'(bus.write_addr), 64'h9);
    chk("same_first_data", 64'(bus.write_data), 64'hA);
    tick();
    bus.req_valid = '0;
    chk("same_second_we", 64'(bus.write_en), 64'h1);
    chk("same_second_data", 64'(bus.write_data), 64'hB);
    set_req(REQ_LSU, 5'd4, 32'h44);
    bus.req_valid = 3'b010;
    #1;
    chk("pre_rst_ready", 64'(bus.req_ready), 64'h2);
    tick();
    rst = 1'b1;
    set_req(REQ_MDU, 5'd6, 32'h66);
    bus.req_valid = 3'b110;
    #1;
    chk("in_rst_ready", 64'(bus.req_ready), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_we", 64'(bus.write_en), 64'h0);
    chk("post_rst_ready", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = '0;
    chk("post_rst_addr", 64'(bus.write_addr), 64'h4);
    chk("post_rst_data", 64'(bus.write_data), 64'h44);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
